// File: rtl/adc_stream_packetizer.sv
// ADC sample framer: registered capture, packet-length write FSM,
// FWFT FIFO with overflow accounting, AXI4-Stream master output.
module adc_stream_packetizer #(
  parameter int ADC_DWIDTH = 256,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_WIDTH  = 32,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    capture_en_i,
  input  logic                    mode_i,
  input  logic [LEN_WIDTH-1:0]    length_i,
  input  logic                    clear_i,
  input  logic [ADC_DWIDTH-1:0]   adc_data_i,
  input  logic                    adc_data_valid_i,
  input  logic                    m_axis_adc_tready,
  output logic                    m_axis_adc_tvalid,
  output logic [ADC_DWIDTH-1:0]   m_axis_adc_tdata,
  output logic [ADC_DWIDTH/8-1:0] m_axis_adc_tkeep,
  output logic                    m_axis_adc_tlast,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  output logic [AW:0]             fifo_level_o,
  output logic [31:0]             frame_cnt_o
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                 state_q;
  logic [ADC_DWIDTH-1:0]  data_q;
  logic                   vld_q;
  logic                   cap_q;
  logic                   cap_qq;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic [AW:0]            wr_ptr_q;
  logic [AW:0]            rd_ptr_q;
  logic [ADC_DWIDTH:0]    mem_q [FIFO_DEPTH];
  logic                   overflow_q;
  logic [15:0]            drop_cnt_q;
  logic [31:0]            frame_cnt_q;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic drop;
  logic last_beat;
  logic arm;
  logic [ADC_DWIDTH:0] head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wr_en = (state_q == CAPTURE) && vld_q && !full;
  assign drop  = (state_q == CAPTURE) && vld_q && full;
  assign rd_en = !empty && m_axis_adc_tready;

  assign last_beat = (beat_cnt_q == len_q);
  // single-shot needs a fresh edge; continuous is level-armed
  assign arm = mode_i ? cap_q : (cap_q && !cap_qq);

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign m_axis_adc_tvalid = !empty;
  assign m_axis_adc_tdata  = empty ? '0 : head[ADC_DWIDTH-1:0];
  assign m_axis_adc_tlast  = !empty && head[ADC_DWIDTH];
  assign m_axis_adc_tkeep  = '1;

  assign busy_o       = (state_q == CAPTURE);
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign fifo_level_o = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk_i) begin
    data_q <= adc_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_q  <= 1'b0;
      cap_q  <= 1'b0;
      cap_qq <= 1'b0;
    end else begin
      vld_q  <= adc_data_valid_i;
      cap_q  <= capture_en_i;
      cap_qq <= cap_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            len_q      <= length_i;
            beat_cnt_q <= '0;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (wr_en && last_beat) begin
            beat_cnt_q <= '0;
            if (mode_i && cap_q) len_q <= length_i;
            else                 state_q <= IDLE;
          end else if (wr_en) begin
            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {last_beat, data_q};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // a drop coinciding with clear survives as the first new event
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (clear_i) begin
      overflow_q  <= drop;
      drop_cnt_q  <= {15'd0, drop};
      frame_cnt_q <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (drop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
      if (rd_en && m_axis_adc_tlast)
        frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

endmodule
